multicycle_seq_ctrl: RTL
========================

// Module: multicycle_seq_ctrl
// PURPOSE
//  Multicycle sequencer for the 16-bit, 3-bit-opcode CPU; replaces single-cycle decode as datapath controller.
//  Steps FETCH/DECODE/EXEC/MEM/WB, drives register enables and mux selects, and shares one memory port
//  between instruction fetch and lw/sw through a req/ready handshake. Counts retired instructions and
//  flags a sticky bus error on memory timeout.
// PARAMETERS
//  TIMEOUT  16  max mem_req cycles without mem_ready before ERR; 0 = never time out
//  CNT_W    16  width of retired_cnt
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      synchronous, active-high
//  opcode        in   3      IR[15:13]; valid from DECODE onward
//  alu_zero      in   1      ALU zero flag (beq compare)
//  mem_ready     in   1      memory completes current access this cycle
//  mem_req       out  1      memory access request
//  mem_we        out  1      1 = write (sw), valid with mem_req
//  iord          out  1      mem addr select: 0 = PC, 1 = ALUOut
//  ir_write      out  1      load IR from memory data
//  mdr_write     out  1      load MDR from memory data
//  pc_write      out  1      unconditional PC load
//  pc_write_cond out  1      PC load if alu_zero
//  pc_src        out  2      00 ALU result, 01 ALUOut (branch target), 10 jump target
//  alu_src_a     out  1      0 = PC, 1 = rs
//  alu_src_b     out  2      00 rt, 01 const 2, 10 ext(imm), 11 sext(imm)<<1
//  alu_op        out  2      00 R-type add, 01 subtract, 10 shift-left-imm, 11 add
//  reg_dst       out  2      00 rt, 01 rd, 10 r7 (link)
//  mem_to_reg    out  2      00 ALUOut, 01 MDR, 10 PC
//  reg_write     out  1      register file write enable
//  sign_or_zero  out  1      1 = sign-extend imm, 0 = zero-extend
//  state         out  3      FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, ERR 7
//  retired_cnt   out  CNT_W  instructions completed, wraps to 0
//  bus_err       out  1      sticky timeout flag
// BEHAVIOUR
//  - Reset: state<=FETCH, retired_cnt<=0, bus_err<=0, wait counter<=0; in the reset cycle every enable is 0,
//    all selects 0, sign_or_zero=1. Reset mid-access abandons it: mem_req is 0 in the reset cycle.
//  - Outputs combinational from state+opcode (+mem_ready); unlisted outputs 0, sign_or_zero=1 except sli.
//  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=11, pc_src=00. On mem_ready: ir_write=1,
//    pc_write=1 (PC<=PC+2), ->DECODE; else hold.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=11 (branch target->ALUOut). j: pc_write=1, pc_src=10, ->FETCH.
//    jal: same plus reg_write=1, reg_dst=10, mem_to_reg=10 (writes pre-jump PC+2), ->FETCH. Others ->EXEC.
//  - EXEC, alu_src_a=1: add alu_src_b=00 alu_op=00 ->WB; addi b=10 op=11 ->WB; sli b=10 op=10 sign_or_zero=0
//    ->WB; lw/sw b=10 op=11 ->MEM; beq b=00 op=01 pc_write_cond=1 pc_src=01 ->FETCH.
//  - MEM: mem_req=1, iord=1, mem_we=(sw). On mem_ready: lw mdr_write=1 ->WB; sw ->FETCH. Else hold.
//  - WB: reg_write=1; add reg_dst=01 mem_to_reg=00; addi/sli reg_dst=00 mem_to_reg=00; lw reg_dst=00 mem_to_reg=01; ->FETCH.
//  - Cycles with ready memory: j/jal 2, beq 3, add/addi/sli 4, sw 4, lw 5.
//  - retired_cnt +1 on every transition into FETCH from DECODE/EXEC/MEM/WB; wraps 2^CNT_W-1 -> 0.
//  - Wait counter: +1 each cycle mem_req=1 and mem_ready=0, cleared when mem_ready=1 or mem_req=0.
//    TIMEOUT>0 and counter reaches TIMEOUT -> ERR, bus_err<=1. mem_ready in that same cycle wins (no error).
//  - ERR: all enables 0, mem_req=0, no counting; held until reset.
//  - Undefined state encodings -> FETCH next cycle, outputs idle.
// TESTING
//  - Reset then add with mem_ready=1 -> states 0,1,2,4,0; reg_write=1 only in WB with reg_dst=01; retired_cnt=1.
//  - lw, mem_ready delayed 3 cycles in MEM -> mem_req,iord=1 held 4 cycles, mdr_write=1 only in ready cycle, then WB mem_to_reg=01.
//  - beq alu_zero=1 then alu_zero=0 -> pc_write_cond=1, pc_src=01 in EXEC both times; 3 cycles each; cnt +2.
//  - jal -> DECODE shows pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10; back to FETCH after 2 cycles.
//  - TIMEOUT=4, mem_ready stuck 0 in FETCH -> ERR after 4 wait cycles, bus_err=1 held; reset -> FETCH, bus_err=0, cnt=0.
//  - CNT_W=4, 16 j instructions -> retired_cnt wraps to 0; reset asserted mid-MEM of sw -> mem_req=0 that cycle, FETCH next.

Source files
------------

// File: rtl/multicycle_seq_ctrl_if.sv
// Shared memory port between the sequencer and memory.
// The sequencer drives the request; memory answers with ready.
interface multicycle_seq_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_seq_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit CPU.
// Drives datapath enables/selects, counts retired instrs, flags bus timeout.
module multicycle_seq_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           opcode,
  input  logic                 alu_zero,
  multicycle_seq_ctrl_if.master mem,
  output logic                 ir_write,
  output logic                 mdr_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic [1:0]           pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           reg_dst,
  output logic [1:0]           mem_to_reg,
  output logic                 reg_write,
  output logic                 sign_or_zero,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     retired_cnt,
  output logic                 bus_err
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_SLI  = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_BEQ  = 3'd5;
  localparam logic [2:0] OP_J    = 3'd6;
  localparam logic [2:0] OP_JAL  = 3'd7;

  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] TLAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [2:0]    state_q, state_d;
  logic [WW-1:0] wait_q;
  logic          timeout_hit;
  logic          retire;

  // The zero flag is consumed by the datapath via pc_write_cond.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  logic is_add, is_addi, is_sli, is_lw, is_sw, is_beq, is_j, is_jal;
  assign is_add  = (opcode == OP_ADD);
  assign is_addi = (opcode == OP_ADDI);
  assign is_sli  = (opcode == OP_SLI);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);
  assign is_jal  = (opcode == OP_JAL);

  assign state = state_q;
  assign timeout_hit = (TIMEOUT > 0) && (wait_q == TLAST);
  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB});

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Wait counter, retire counter and sticky bus error.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q      <= '0;
      retired_cnt <= '0;
      bus_err     <= 1'b0;
    end else begin
      if (mem.mem_req && !mem.mem_ready) wait_q <= wait_q + 1'b1;
      else                               wait_q <= '0;
      if (retire) retired_cnt <= retired_cnt + 1'b1;
      if (state_d == S_ERR && state_q != S_ERR) bus_err <= 1'b1;
    end
  end

  // Next-state selection; a ready in the last wait cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem.mem_ready)    state_d = S_DECODE;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_DECODE: begin
        if (is_j || is_jal) state_d = S_FETCH;
        else                state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_add || is_addi || is_sli) state_d = S_WB;
        else if (is_lw || is_sw)         state_d = S_MEM;
        else                             state_d = S_FETCH;
      end
      S_MEM: begin
        if (mem.mem_ready)    state_d = is_lw ? S_WB : S_FETCH;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_WB:    state_d = S_FETCH;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_FETCH;
    endcase
  end

  // Datapath controls; everything idles while reset is held.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.iord      = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    sign_or_zero  = 1'b1;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          alu_src_b   = 2'b01;
          alu_op      = 2'b11;
          ir_write    = mem.mem_ready;
          pc_write    = mem.mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_op    = 2'b11;
          if (is_j || is_jal) begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
          end
          if (is_jal) begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          unique case (1'b1)
            is_add: alu_op = 2'b00;
            is_addi, is_lw, is_sw: begin
              alu_src_b = 2'b10;
              alu_op    = 2'b11;
            end
            is_sli: begin
              alu_src_b    = 2'b10;
              alu_op       = 2'b10;
              sign_or_zero = 1'b0;
            end
            is_beq: begin
              alu_op        = 2'b01;
              pc_write_cond = 1'b1;
              pc_src        = 2'b01;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem.mem_req = 1'b1;
          mem.iord    = 1'b1;
          mem.mem_we  = is_sw;
          mdr_write   = is_lw && mem.mem_ready;
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = is_add ? 2'b01 : 2'b00;
          mem_to_reg = is_lw ? 2'b01 : 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule
